// File: rtl/cipher_bridge_pkg.sv
// Shared definitions for the PicoBlaze cipher port bridge: register offsets,
// CTRL/STATUS bit positions and the sequencer state encoding.
package cipher_bridge_pkg;

    // Register offsets relative to the bridge base port_id
    localparam logic [7:0] OFF_KEY        = 8'd0;
    localparam logic [7:0] OFF_DATA       = 8'd1;
    localparam logic [7:0] OFF_RESULT     = 8'd2;
    localparam logic [7:0] OFF_CTRL       = 8'd3;
    localparam logic [7:0] OFF_STATUS     = 8'd4;
    localparam logic [7:0] OFF_STORE_BASE = 8'd5;

    // CTRL bit positions
    localparam int CTRL_START   = 0;
    localparam int CTRL_DECRYPT = 1;
    localparam int CTRL_CLEAR   = 2;
    localparam int CTRL_AUTO    = 3;
    localparam int CTRL_IRQ_EN  = 4;

    // STATUS bit positions (bits 7:5 read as zero)
    localparam int STAT_BUSY      = 0;
    localparam int STAT_DONE      = 1;
    localparam int STAT_KEY_FULL  = 2;
    localparam int STAT_DATA_FULL = 3;
    localparam int STAT_ERROR     = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARM,
        ST_RUN,
        ST_STORE
    } bridge_state_e;

    // Absolute port_id of a register given the bridge base
    function automatic logic [7:0] port_addr(input logic [7:0] base, input logic [7:0] off);
        return base + off;
    endfunction

endpackage

// File: rtl/byte_lane_loader.sv
// Byte-serial loader: each accepted write fills the next byte lane, LSB first.
// A write arriving when every lane is filled is dropped and flagged.
module byte_lane_loader #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             wr_i,
    input  logic [7:0]       byte_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             overflow_o
);

    localparam int NBYTES = WIDTH / 8;
    localparam int PW     = $clog2(NBYTES + 1);
    localparam logic [PW-1:0] NB_P = PW'(NBYTES);

    logic [PW-1:0] ptr_q;

    assign full_o     = (ptr_q == NB_P);
    assign overflow_o = wr_i && full_o;

    // Byte pointer: cleared on request, advances on each accepted write
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else if (clr_i) begin
            ptr_q <= '0;
        end else if (wr_i && !full_o) begin
            ptr_q <= ptr_q + PW'(1);
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NBYTES; gi++) begin : g_lane
            logic [7:0] lane_q;

            // Lane register: captures the write byte when the pointer selects it
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    lane_q <= 8'h00;
                end else if (wr_i && !full_o && (ptr_q == PW'(gi))) begin
                    lane_q <= byte_i;
                end
            end

            assign data_o[gi*8 +: 8] = lane_q;
        end
    endgenerate

endmodule

// File: rtl/cipher_port_bridge.sv
// PicoBlaze I/O-port front end for a block cipher core: loads key and data
// bytes, launches the core, captures the result and optionally streams it
// byte-wise into a result store, with a STATUS register and level interrupt.
module cipher_port_bridge
    import cipher_bridge_pkg::*;
#(
    parameter int         BLOCK_W = 64,
    parameter int         KEY_W   = 128,
    parameter logic [7:0] BASE    = 8'h30
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         port_id,
    input  logic [7:0]         out_port,
    input  logic               write_strobe,
    input  logic               read_strobe,
    output logic [7:0]         in_port,
    output logic               core_start,
    output logic               core_decrypt,
    output logic [KEY_W-1:0]   core_key,
    output logic [BLOCK_W-1:0] core_din,
    input  logic [BLOCK_W-1:0] core_dout,
    input  logic               core_ready,
    output logic [7:0]         mem_addr,
    output logic [7:0]         mem_din,
    output logic               mem_we,
    output logic               irq
);

    localparam int         BLOCK_BYTES   = BLOCK_W / 8;
    localparam logic [7:0] LAST_IDX      = 8'(BLOCK_BYTES - 1);
    localparam logic [7:0] BLOCK_BYTES_B = 8'(BLOCK_BYTES);

    localparam logic [7:0] ADDR_KEY    = port_addr(BASE, OFF_KEY);
    localparam logic [7:0] ADDR_DATA   = port_addr(BASE, OFF_DATA);
    localparam logic [7:0] ADDR_RESULT = port_addr(BASE, OFF_RESULT);
    localparam logic [7:0] ADDR_CTRL   = port_addr(BASE, OFF_CTRL);
    localparam logic [7:0] ADDR_STATUS = port_addr(BASE, OFF_STATUS);
    localparam logic [7:0] ADDR_SBASE  = port_addr(BASE, OFF_STORE_BASE);

    bridge_state_e      state_q, state_d;
    logic               decrypt_q, auto_store_q, irq_en_q;
    logic               done_q, error_q;
    logic [7:0]         store_ptr_q, idx_q, rptr_q;
    logic [BLOCK_W-1:0] result_q;

    logic key_wr, data_wr, ctrl_wr, status_wr, sbase_wr, result_rd;
    logic busy, clear_ptrs, err_set;
    logic start_ok, capture, finish, store_last;
    logic key_full, data_full, key_ovf, data_ovf;
    logic [7:0] status;

    assign key_wr    = write_strobe && (port_id == ADDR_KEY);
    assign data_wr   = write_strobe && (port_id == ADDR_DATA);
    assign ctrl_wr   = write_strobe && (port_id == ADDR_CTRL);
    assign status_wr = write_strobe && (port_id == ADDR_STATUS);
    assign sbase_wr  = write_strobe && (port_id == ADDR_SBASE);
    assign result_rd = read_strobe  && (port_id == ADDR_RESULT);

    assign busy       = (state_q != ST_IDLE);
    assign clear_ptrs = ctrl_wr && out_port[CTRL_CLEAR];

    // Busy-time writes to KEY/DATA/STORE_BASE and a busy start are dropped
    // and flagged, as are overflowing KEY/DATA writes.
    assign err_set = key_ovf || data_ovf
                   || (busy && (key_wr || data_wr || sbase_wr))
                   || (busy && ctrl_wr && out_port[CTRL_START]);

    byte_lane_loader #(.WIDTH(KEY_W)) u_key_loader (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (clear_ptrs),
        .wr_i       (key_wr && !busy),
        .byte_i     (out_port),
        .data_o     (core_key),
        .full_o     (key_full),
        .overflow_o (key_ovf)
    );

    byte_lane_loader #(.WIDTH(BLOCK_W)) u_data_loader (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (clear_ptrs),
        .wr_i       (data_wr && !busy),
        .byte_i     (out_port),
        .data_o     (core_din),
        .full_o     (data_full),
        .overflow_o (data_ovf)
    );

    // Sequencer next state and core/store outputs
    always_comb begin
        state_d    = state_q;
        start_ok   = 1'b0;
        capture    = 1'b0;
        finish     = 1'b0;
        store_last = 1'b0;
        core_start = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = 8'h00;
        mem_din    = 8'h00;
        case (state_q)
            ST_IDLE: begin
                if (ctrl_wr && out_port[CTRL_START]) begin
                    start_ok = 1'b1;
                    state_d  = ST_ARM;
                end
            end
            ST_ARM: begin
                // Core is being kicked this cycle; a stale ready is ignored
                core_start = 1'b1;
                state_d    = ST_RUN;
            end
            ST_RUN: begin
                if (core_ready) begin
                    capture = 1'b1;
                    if (auto_store_q) begin
                        state_d = ST_STORE;
                    end else begin
                        finish  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_STORE: begin
                mem_we   = 1'b1;
                mem_addr = store_ptr_q + idx_q;
                mem_din  = result_q[{idx_q, 3'b000} +: 8];
                if (idx_q == LAST_IDX) begin
                    store_last = 1'b1;
                    finish     = 1'b1;
                    state_d    = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Sequencer state, mode bits, flags, result and store bookkeeping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            decrypt_q    <= 1'b0;
            auto_store_q <= 1'b0;
            irq_en_q     <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            result_q     <= '0;
            rptr_q       <= 8'h00;
            idx_q        <= 8'h00;
            store_ptr_q  <= 8'h00;
        end else begin
            state_q <= state_d;

            if (ctrl_wr) begin
                decrypt_q    <= out_port[CTRL_DECRYPT];
                auto_store_q <= out_port[CTRL_AUTO];
                irq_en_q     <= out_port[CTRL_IRQ_EN];
            end

            // Setting a flag takes priority over a coincident W1C
            if (err_set) begin
                error_q <= 1'b1;
            end else if (status_wr && out_port[STAT_ERROR]) begin
                error_q <= 1'b0;
            end

            if (finish) begin
                done_q <= 1'b1;
            end else if (start_ok || (status_wr && out_port[STAT_DONE])) begin
                done_q <= 1'b0;
            end

            if (capture) begin
                result_q <= core_dout;
            end

            if (capture || clear_ptrs) begin
                rptr_q <= 8'h00;
            end else if (result_rd) begin
                rptr_q <= (rptr_q == LAST_IDX) ? 8'h00 : rptr_q + 8'd1;
            end

            if (state_q == ST_STORE && !store_last) begin
                idx_q <= idx_q + 8'd1;
            end else begin
                idx_q <= 8'h00;
            end

            if (store_last) begin
                store_ptr_q <= store_ptr_q + BLOCK_BYTES_B;
            end else if (sbase_wr && !busy) begin
                store_ptr_q <= out_port;
            end
        end
    end

    // STATUS image and read-port multiplexer
    always_comb begin
        status                 = 8'h00;
        status[STAT_BUSY]      = busy;
        status[STAT_DONE]      = done_q;
        status[STAT_KEY_FULL]  = key_full;
        status[STAT_DATA_FULL] = data_full;
        status[STAT_ERROR]     = error_q;
        in_port                = 8'h00;
        if (port_id == ADDR_RESULT) begin
            in_port = result_q[{rptr_q, 3'b000} +: 8];
        end else if (port_id == ADDR_STATUS) begin
            in_port = status;
        end
    end

    assign core_decrypt = decrypt_q;
    assign irq          = irq_en_q && (done_q || error_q);

endmodule

// File: tb/tb_cipher_port_bridge.sv
// Randomised self-checking bench for cipher_port_bridge with a stub cipher
// core (result = ~din, ~10 cycles) and a byte-level reference model.
module tb_cipher_port_bridge;

    localparam int         NB   = 8;
    localparam int         NK   = 16;
    localparam logic [7:0] BASE = 8'h30;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [7:0]   port_id = 8'h00, out_port = 8'h00;
    logic         write_strobe = 1'b0, read_strobe = 1'b0;
    logic [7:0]   in_port;
    logic         core_start, core_decrypt;
    logic [127:0] core_key;
    logic [63:0]  core_din, core_dout;
    logic         core_ready;
    logic [7:0]   mem_addr, mem_din;
    logic         mem_we, irq;

    cipher_port_bridge #(.BLOCK_W(64), .KEY_W(128), .BASE(BASE)) dut (
        .clk(clk), .rst(rst), .port_id(port_id), .out_port(out_port),
        .write_strobe(write_strobe), .read_strobe(read_strobe), .in_port(in_port),
        .core_start(core_start), .core_decrypt(core_decrypt), .core_key(core_key),
        .core_din(core_din), .core_dout(core_dout), .core_ready(core_ready),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we), .irq(irq)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic [7:0] m_key [NK];
    logic [7:0] m_data[NB];
    logic [7:0] m_res [NB];
    logic [7:0] m_pend[NB];
    int         m_kp, m_dp, m_rp;
    logic [7:0] m_sp;
    logic       m_done, m_err, m_busy, m_dec, m_auto, m_irqen, m_start_dec;

    // Observations gathered by the stub core / store monitor
    int          starts;
    logic        seen_dec;
    logic [15:0] stq[$];
    logic [63:0] latched_din;
    int          cnt;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NK; i++) m_key[i] = 8'h00;
        for (int i = 0; i < NB; i++) begin m_data[i] = 8'h00; m_res[i] = 8'h00; end
        m_kp = 0; m_dp = 0; m_rp = 0; m_sp = 8'h00;
        m_done = 0; m_err = 0; m_busy = 0; m_dec = 0; m_auto = 0; m_irqen = 0;
    endtask

    function automatic logic [7:0] m_status();
        return {3'b000, m_err, (m_dp == NB), (m_kp == NK), m_done, m_busy};
    endfunction

    function automatic logic [127:0] m_key_vec();
        logic [127:0] v = '0;
        for (int i = 0; i < NK; i++) v[8*i +: 8] = m_key[i];
        return v;
    endfunction

    // Stub cipher core: on start, briefly shows a poisoned ready, then
    // returns ~din about ten cycles later and holds ready high.
    initial begin
        core_ready = 1'b0; core_dout = '0; cnt = 0; starts = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                core_ready = 1'b0; cnt = 0;
            end else if (core_start) begin
                starts++;
                seen_dec    = core_decrypt;
                latched_din = core_din;
                core_dout   = {$urandom, $urandom};
                core_ready  = 1'b1;
                cnt         = 10;
            end else if (cnt > 0) begin
                core_ready = 1'b0;
                cnt--;
                if (cnt == 0) begin
                    core_dout  = ~latched_din;
                    core_ready = 1'b1;
                end
            end
        end
    end

    // Result-store monitor
    initial forever begin
        @(negedge clk);
        if (mem_we) stq.push_back({mem_addr, mem_din});
    end

    task automatic wr(input logic [7:0] off, input logic [7:0] v);
        @(negedge clk);
        port_id = BASE + off; out_port = v; write_strobe = 1'b1;
        @(negedge clk);
        write_strobe = 1'b0; port_id = 8'h00;
        case (off)
            8'd0: if (m_busy || m_kp == NK) m_err = 1; else begin m_key[m_kp] = v; m_kp++; end
            8'd1: if (m_busy || m_dp == NB) m_err = 1; else begin m_data[m_dp] = v; m_dp++; end
            8'd3: begin
                m_dec = v[1]; m_auto = v[3]; m_irqen = v[4];
                if (v[0]) begin
                    if (m_busy) m_err = 1;
                    else begin
                        m_busy = 1; m_done = 0; m_start_dec = v[1];
                        for (int i = 0; i < NB; i++) m_pend[i] = ~m_data[i];
                    end
                end
                if (v[2]) begin m_kp = 0; m_dp = 0; m_rp = 0; end
            end
            8'd4: begin if (v[1]) m_done = 0; if (v[4]) m_err = 0; end
            8'd5: if (m_busy) m_err = 1; else m_sp = v;
            default: ;
        endcase
    endtask

    task automatic rd_chk(input string tag, input logic [7:0] off);
        logic [7:0] exp;
        @(negedge clk);
        port_id = BASE + off; read_strobe = 1'b1;
        #1;
        if (off == 8'd2) begin
            exp  = m_res[m_rp];
            m_rp = (m_rp + 1) % NB;
        end else if (off == 8'd4) begin
            exp = m_status();
        end else begin
            exp = 8'h00;
        end
        check(tag, in_port, exp);
        @(negedge clk);
        read_strobe = 1'b0; port_id = 8'h00;
    endtask

    // Wait (bounded) for the operation to finish, then check its effects
    task automatic run_to_done();
        int n = 0;
        port_id = BASE + 8'd4;
        @(negedge clk);
        while (in_port[0] && n < 200) begin @(negedge clk); n++; end
        check("busy_timeout", in_port[0], 1'b0);
        port_id = 8'h00;
        check("start_count", starts, 1);
        check("core_decrypt", seen_dec, m_start_dec);
        m_busy = 0; m_done = 1; m_rp = 0;
        for (int i = 0; i < NB; i++) m_res[i] = m_pend[i];
        if (m_auto) begin
            check("store_count", stq.size(), NB);
            for (int i = 0; i < NB && i < stq.size(); i++)
                check($sformatf("store%0d", i), stq[i], {8'(m_sp + 8'(i)), m_res[i]});
            m_sp = m_sp + 8'(NB);
        end else begin
            check("store_count", stq.size(), 0);
        end
        stq.delete();
        starts = 0;
        check("irq_done", irq, m_irqen & (m_done | m_err));
    endtask

    initial begin
        int n;
        logic [7:0] c;
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_mem_we", mem_we, 1'b0);
        check("rst_core_start", core_start, 1'b0);
        check("rst_irq", irq, 1'b0);
        rd_chk("rst_status", 8'd4);
        rd_chk("rst_result", 8'd2);
        rd_chk("unmapped", 8'd7);

        // Known-answer block: key 00..0F, data 41..48
        for (int i = 0; i < NK; i++) wr(8'd0, 8'(i));
        for (int i = 0; i < NB; i++) wr(8'd1, 8'(8'h41 + i));
        check("core_key", core_key, m_key_vec());
        wr(8'd3, 8'h01);
        run_to_done();
        rd_chk("kat_status", 8'd4);
        for (int i = 0; i <= NB; i++) rd_chk($sformatf("kat_res%0d", i), 8'd2);

        // Key overflow sets error, leaves key intact; W1C clears error
        wr(8'd3, 8'h04);
        wr(8'd4, 8'h02);
        for (int i = 0; i < NK; i++) wr(8'd0, 8'($urandom));
        wr(8'd0, 8'hEE);
        rd_chk("ovf_status", 8'd4);
        check("ovf_key", core_key, m_key_vec());
        wr(8'd4, 8'h10);
        rd_chk("w1c_status", 8'd4);

        // Auto-store with address wrap, then a second block continuing on
        for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < NB; i++) wr(8'd1, 8'($urandom));
            if (b == 0) wr(8'd5, 8'hFC);
            wr(8'd3, 8'h09);
            run_to_done();
            wr(8'd3, 8'h04);
        end

        // Start while busy is rejected; ready during ARM is ignored
        for (int i = 0; i < NB; i++) wr(8'd1, 8'($urandom));
        wr(8'd3, 8'h01);
        wr(8'd3, 8'h01);
        run_to_done();
        rd_chk("busy_status", 8'd4);
        rd_chk("busy_res0", 8'd2);

        // Interrupt on completion, cleared by W1C of done
        wr(8'd4, 8'h12);
        wr(8'd3, 8'h11);
        run_to_done();
        check("irq_set", irq, 1'b1);
        wr(8'd4, 8'h02);
        #1;
        check("irq_clr", irq, 1'b0);

        // Randomised operations
        for (int it = 0; it < 8; it++) begin
            wr(8'd3, 8'h04);
            wr(8'd4, 8'h12);
            n = $urandom_range(0, 17);
            for (int i = 0; i < n; i++) wr(8'd0, 8'($urandom));
            n = $urandom_range(0, 9);
            for (int i = 0; i < n; i++) wr(8'd1, 8'($urandom));
            check("rnd_key", core_key, m_key_vec());
            if ($urandom_range(0, 1) == 1) wr(8'd5, 8'($urandom));
            c = {3'b000, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'b1};
            wr(8'd3, c);
            if ($urandom_range(0, 1) == 1) wr(8'd0, 8'($urandom));
            run_to_done();
            n = $urandom_range(0, 10);
            for (int i = 0; i < n; i++) rd_chk("rnd_res", 8'd2);
            rd_chk("rnd_status", 8'd4);
            wr(8'd4, 8'($urandom) & 8'h12);
            #1;
            check("rnd_irq", irq, m_irqen & (m_done | m_err));
        end

        // Reset in the middle of a store burst
        for (int i = 0; i < NB; i++) wr(8'd1, 8'($urandom));
        wr(8'd3, 8'h09);
        n = 0;
        while (stq.size() < 3 && n < 200) begin @(negedge clk); n++; end
        check("store_timeout", (stq.size() >= 3), 1'b1);
        #1 rst = 1'b1;
        #1;
        check("midrst_mem_we", mem_we, 1'b0);
        check("midrst_mem_addr", mem_addr, 8'h00);
        check("midrst_irq", irq, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        stq.delete();
        starts = 0;
        repeat (12) @(negedge clk);
        check("post_rst_stores", stq.size(), 0);
        check("post_rst_starts", starts, 0);
        rd_chk("post_rst_status", 8'd4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/cipher_port_bridge.md
CIPHER_PORT_BRIDGE -- requirements
Module: cipher_port_bridge

Interface
REQ-001 SHALL have parameter BLOCK_W, default 64, cipher block width in bits (multiple of 8, 8..128).
REQ-002 SHALL have parameter KEY_W, default 128, key width in bits (multiple of 8, 8..256).
REQ-003 SHALL have parameter BASE, default 8'h30, port_id of register offset 0.
REQ-004 SHALL have ports (clock and reset first):
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- port_id  in  8  PicoBlaze port address
- out_port  in  8  PicoBlaze write data
- write_strobe  in  1  write qualifier
- read_strobe  in  1  read qualifier
- in_port  out  8  read data, combinational
- core_start  out  1  one-cycle start pulse to cipher core
- core_decrypt  out  1  mode to core
- core_key  out  KEY_W  key to core
- core_din  out  BLOCK_W  block to core
- core_dout  in  BLOCK_W  core result
- core_ready  in  1  core result valid (level)
- mem_addr  out  8  result-store address
- mem_din  out  8  result-store data
- mem_we  out  1  result-store write enable
- irq  out  1  level interrupt

Function
REQ-005 Register map (BASE+n): +0 KEY wr, +1 DATA wr, +2 RESULT rd, +3 CTRL wr, +4 STATUS rd / W1C wr, +5 STORE_BASE wr.
REQ-006 KEY/DATA writes SHALL load byte [8p+7:8p] at pointer p (LSB first), then p+1; write with p==KEY_W/8 (resp. BLOCK_W/8) ignored, sets error.
REQ-007 CTRL bits: 0 start, 1 decrypt, 2 clear key/data/result pointers, 3 auto-store enable, 4 irq enable; bits 1,3,4 latched every CTRL write.
REQ-008 STATUS bits: 0 busy, 1 done, 2 key_full, 3 data_full, 4 error, 7:5 zero; write with bit1/bit4 set clears done/error.
REQ-009 RESULT read SHALL return byte at result pointer r; r increments on read_strobe, wraps modulo BLOCK_W/8.
REQ-010 Unmapped or non-read port_id SHALL give in_port=8'h00.
REQ-011 FSM states IDLE, ARM, RUN, STORE.
REQ-012 IDLE: CTRL start=1 -> core_start high next cycle for exactly one cycle, core_decrypt=bit1, busy=1, done=0, go ARM.
REQ-013 ARM: one cycle, core_ready ignored, go RUN.
REQ-014 RUN: first cycle core_ready=1 captures core_dout into result register, r=0; go STORE if auto-store else IDLE with done=1.
REQ-015 STORE: BLOCK_W/8 cycles, mem_we=1, mem_addr=store_ptr+i (mod 256), mem_din=result byte i LSB first; then store_ptr+=BLOCK_W/8 (wraps), done=1, go IDLE.
REQ-016 STORE_BASE write sets store_ptr; ignored and error set while busy.
REQ-017 While busy, KEY/DATA/CTRL-start writes ignored, error set; RESULT reads return previous result.
REQ-018 CTRL with start and clear together: start accepted, then pointers cleared same cycle.
REQ-019 irq = irq_en & (done | error).
REQ-020 STATUS W1C coincident with done set: set wins.

Reset
REQ-021 rst SHALL asynchronously clear all pointers, key, data, result, store_ptr, flags, mode bits; FSM to IDLE; core_start, mem_we, irq, mem_addr, mem_din = 0.
REQ-022 rst mid-RUN/STORE SHALL abort with no further mem_we or core_start.

Structure
REQ-023 Register offsets, CTRL/STATUS bit positions, FSM state enum SHALL live in shared package cipher_bridge_pkg.
REQ-024 One sub-module, byte_lane_loader (pointer + byte insert, parametrised width), instantiated for KEY and DATA.

Verification
REQ-025 Load 16 key bytes 00..0F, 8 data bytes 41..48, CTRL=8'h01, stub core returns ~din after 10 cycles -> RESULT reads BE,BD,...,B7, done=1.
REQ-026 17th KEY write -> STATUS=8'h14 (error, key_full), key unchanged; STATUS write 8'h10 -> error cleared.
REQ-027 STORE_BASE=8'hFC, CTRL=8'h09 -> 8 mem_we cycles at FC,FD,FE,FF,00..03; next block stores from 04.
REQ-028 CTRL=8'h01 while busy -> no second core_start, error=1; core_ready asserted during ARM ignored.
REQ-029 CTRL=8'h11, completion -> irq=1; STATUS write 8'h02 -> irq=0.
REQ-030 rst mid-STORE -> mem_we=0 immediately, STATUS=8'h00 after release.
